ref_clock_divider: RTL and testbench



---
 rtl/ref_clock_divider_pkg.sv | 13 +
 rtl/ref_clock_divider.sv | 68 ++++++
 tb/tb_ref_clock_divider.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/ref_clock_divider_pkg.sv
// Shared constants for the reference clock divider, also used by the system register file.
package ref_clock_divider_pkg;

  localparam int DIV_RATIO_WIDTH = 8;
  // Ratios at or below this value bypass the divider.
  localparam int DIV_BYPASS_MAX  = 1;

  typedef enum logic {
    PHASE_LOW  = 1'b0,
    PHASE_HIGH = 1'b1
  } div_phase_e;

endpackage

// File: rtl/ref_clock_divider.sv
// Integer clock divider with runtime ratio; odd ratios carry the extra cycle in the low phase.
//
//   state      | meaning
//   -----------|--------------------------------------------------
//   PHASE_LOW  | divided clock low, counting ceil(N/2) ref cycles
//   PHASE_HIGH | divided clock high, counting floor(N/2) ref cycles
module ref_clock_divider
  import ref_clock_divider_pkg::*;
#(
  parameter int RATIO_WIDTH = DIV_RATIO_WIDTH
) (
  input  logic                   i_ref_clk,
  input  logic                   i_rst,
  input  logic                   i_clk_en,
  input  logic [RATIO_WIDTH-1:0] i_div_ratio,
  output logic                   o_div_clk
);

  div_phase_e             phase_q;
  div_phase_e             phase_d;
  logic [RATIO_WIDTH-1:0] cnt_q;
  logic [RATIO_WIDTH-1:0] cnt_d;
  logic [RATIO_WIDTH-1:0] phase_last;
  logic                   active;
  logic                   div_q;

  assign active = i_clk_en && (i_div_ratio > RATIO_WIDTH'(DIV_BYPASS_MAX));

  // Phase length is taken from the live ratio, so a ratio change reshapes the
  // phase already in progress; >= lets an overshooting count toggle at once.
  always_comb begin
    phase_last = '0;
    cnt_d      = '0;
    phase_d    = PHASE_LOW;
    if (phase_q == PHASE_LOW) begin
      phase_last = (i_div_ratio - RATIO_WIDTH'(1)) >> 1;
    end else begin
      phase_last = (i_div_ratio >> 1) - RATIO_WIDTH'(1);
    end
    if (active) begin
      if (cnt_q >= phase_last) begin
        cnt_d = '0;
        case (phase_q)
          PHASE_LOW:  phase_d = PHASE_HIGH;
          PHASE_HIGH: phase_d = PHASE_LOW;
          default:    phase_d = PHASE_LOW;
        endcase
      end else begin
        cnt_d   = cnt_q + RATIO_WIDTH'(1);
        phase_d = phase_q;
      end
    end
  end

  always_ff @(posedge i_ref_clk) begin
    if (i_rst) begin
      cnt_q   <= '0;
      phase_q <= PHASE_LOW;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  assign div_q     = (phase_q == PHASE_HIGH);
  assign o_div_clk = active ? div_q : i_ref_clk;

endmodule

// File: tb/tb_ref_clock_divider.sv
// Directed bench for ref_clock_divider: ratios, bypass, ratio change, mid-run enable drop and reset.
module tb_ref_clock_divider;

  logic       i_ref_clk = 1'b0;
  logic       i_rst;
  logic       i_clk_en;
  logic [7:0] i_div_ratio;
  logic       o_div_clk;

  int err_cnt = 0;
  int chk_cnt = 0;

  ref_clock_divider #(.RATIO_WIDTH(8)) dut (
    .i_ref_clk  (i_ref_clk),
    .i_rst      (i_rst),
    .i_clk_en   (i_clk_en),
    .i_div_ratio(i_div_ratio),
    .o_div_clk  (o_div_clk)
  );

  always #5 i_ref_clk = ~i_ref_clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge i_ref_clk);
    #1;
  endtask

  task automatic do_reset(input logic en, input logic [7:0] n);
    i_rst       = 1'b1;
    i_clk_en    = en;
    i_div_ratio = n;
    step();
    step();
    i_rst = 1'b0;
  endtask

  // Edge k after a fresh start: output high when (k mod N) >= ceil(N/2).
  task automatic run_check(input string tag, input int n, input int edges, input int k0);
    for (int k = k0 + 1; k <= k0 + edges; k++) begin
      step();
      check_val(tag, 32'(o_div_clk), 32'(((k % n) >= ((n + 1) / 2)) ? 1 : 0));
    end
  endtask

  task automatic bypass_check(input string tag);
    for (int i = 0; i < 3; i++) begin
      @(posedge i_ref_clk);
      #1;
      check_val({tag, "_hi"}, 32'(o_div_clk), 32'd1);
      @(negedge i_ref_clk);
      #1;
      check_val({tag, "_lo"}, 32'(o_div_clk), 32'd0);
    end
  endtask

  task automatic measure_period(input string tag, input int n);
    int   rises;
    logic prev;
    time  t_first;
    time  period;
    rises   = 0;
    prev    = 1'b0;
    t_first = 0;
    period  = 0;
    do_reset(1'b1, 8'(n));
    for (int i = 0; i < 4 * n && rises < 2; i++) begin
      step();
      if (o_div_clk === 1'b1 && prev === 1'b0) begin
        if (rises == 0) t_first = $time;
        else            period  = $time - t_first;
        rises++;
      end
      prev = o_div_clk;
    end
    check_val(tag, 32'(period), 32'(n * 10));
  endtask

  initial begin
    i_rst       = 1'b1;
    i_clk_en    = 1'b0;
    i_div_ratio = 8'd0;

    // Active during reset reads 0.
    do_reset(1'b1, 8'd3);
    i_rst = 1'b1;
    step();
    check_val("rst_active_low", 32'(o_div_clk), 32'd0);
    i_rst = 1'b0;

    // N=2: toggles every edge, starting low.
    do_reset(1'b1, 8'd2);
    check_val("n2_start", 32'(o_div_clk), 32'd0);
    run_check("n2", 2, 8, 0);

    // N=3: first rise on edge 2, then 2 low / 1 high.
    do_reset(1'b1, 8'd3);
    step();
    check_val("n3_edge1", 32'(o_div_clk), 32'd0);
    step();
    check_val("n3_edge2_rise", 32'(o_div_clk), 32'd1);
    run_check("n3", 3, 9, 2);

    do_reset(1'b1, 8'd4);
    run_check("n4", 4, 12, 0);
    do_reset(1'b1, 8'd5);
    run_check("n5", 5, 15, 0);
    measure_period("period_n4", 4);
    measure_period("period_n5", 5);

    // Bypass modes follow the reference clock, including under reset.
    do_reset(1'b0, 8'd2);
    bypass_check("byp_en0");
    i_clk_en = 1'b1; i_div_ratio = 8'd1;
    bypass_check("byp_n1");
    i_div_ratio = 8'd0;
    bypass_check("byp_n0");
    i_clk_en = 1'b0; i_div_ratio = 8'd4; i_rst = 1'b1;
    bypass_check("byp_rst");
    i_rst = 1'b0;

    // Ratio change 8 -> 2 at cnt=3, and at cnt=1 where N=8 would not toggle.
    do_reset(1'b1, 8'd8);
    run_check("n8_pre", 8, 3, 0);
    i_div_ratio = 8'd2;
    step();
    check_val("chg_cnt3_toggle", 32'(o_div_clk), 32'd1);
    for (int i = 0; i < 4; i++) begin
      step();
      check_val("chg_cnt3_n2", 32'(o_div_clk), 32'(i % 2 == 0 ? 0 : 1));
    end
    do_reset(1'b1, 8'd8);
    step();
    i_div_ratio = 8'd2;
    step();
    check_val("chg_cnt1_toggle", 32'(o_div_clk), 32'd1);
    step();
    check_val("chg_cnt1_fall", 32'(o_div_clk), 32'd0);

    // Enable dropped while divided clock is high and reference clock low.
    do_reset(1'b1, 8'd4);
    run_check("en_drop_pre", 4, 3, 0);
    @(negedge i_ref_clk);
    #1;
    i_clk_en = 1'b0;
    #1;
    check_val("en_drop_immediate", 32'(o_div_clk), 32'd0);
    step();
    i_clk_en = 1'b1;
    #1;
    check_val("en_reenable_low", 32'(o_div_clk), 32'd0);
    run_check("en_reenable", 4, 8, 0);

    // Reset mid high phase restarts a fresh low phase.
    do_reset(1'b1, 8'd8);
    run_check("mid_rst_pre", 8, 6, 0);
    i_rst = 1'b1;
    step();
    check_val("mid_rst_clear", 32'(o_div_clk), 32'd0);
    i_rst = 1'b0;
    run_check("mid_rst_post", 8, 10, 0);

    // Maximum ratio: 128 low / 127 high, no counter wrap.
    do_reset(1'b1, 8'd255);
    check_val("n255_start", 32'(o_div_clk), 32'd0);
    run_check("n255", 255, 510, 0);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
